// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, immediate types,
// ALU/MDU operation codes, FSM states and the latched control bundle.
package ctrl_pkg;

  localparam logic [6:0] TYPE_LUI       = 7'b0110111;
  localparam logic [6:0] TYPE_AUIPC     = 7'b0010111;
  localparam logic [6:0] TYPE_JAL       = 7'b1101111;
  localparam logic [6:0] TYPE_JALR      = 7'b1100111;
  localparam logic [6:0] TYPE_BRANCH    = 7'b1100011;
  localparam logic [6:0] TYPE_LOAD      = 7'b0000011;
  localparam logic [6:0] TYPE_STORE     = 7'b0100011;
  localparam logic [6:0] TYPE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] TYPE_OP        = 7'b0110011;
  localparam logic [6:0] TYPE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] TYPE_OP_32     = 7'b0111011;
  localparam logic [6:0] TYPE_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;

  typedef enum logic [2:0] {
    IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
  } imm_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLL   = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR    = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND    = 5'd9,  ALU_MUL   = 5'd10, ALU_MULH = 5'd11,
    ALU_MULHSU = 5'd12, ALU_MULHU  = 5'd13, ALU_DIV   = 5'd14, ALU_DIVU = 5'd15,
    ALU_REM    = 5'd16, ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
    ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    imm_e       imm;
    logic       asrc;
    logic [1:0] bsrc;
    alu_op_e    sel;
    logic       word;
    logic       branch;
    logic       load;
    logic       store;
    logic       wen;
    logic       mop;
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic alu_op_e mdu_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      3'b111:  op = ALU_REMU;
      default: op = ALU_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction word to control bundle plus
// illegal/ebreak flags, honouring the XLEN and M-extension configuration.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        ebreak
);

  localparam logic RV64 = (XLEN == 64);

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;

  assign opcode_s = inst[6:0];
  assign f3_s     = inst[14:12];
  assign f7_s     = inst[31:25];

  // decode table
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    ebreak  = 1'b0;
    case (opcode_s)
      TYPE_LUI: begin
        ctrl.imm = IMM_U; ctrl.bsrc = BSRC_IMM; ctrl.wen = 1'b1;
      end
      TYPE_AUIPC: begin
        ctrl.imm = IMM_U; ctrl.asrc = 1'b1; ctrl.bsrc = BSRC_IMM; ctrl.wen = 1'b1;
      end
      TYPE_JAL: begin
        ctrl.imm = IMM_J; ctrl.asrc = 1'b1; ctrl.bsrc = BSRC_FOUR;
        ctrl.branch = 1'b1; ctrl.wen = 1'b1;
      end
      TYPE_JALR: begin
        ctrl.imm = IMM_I; ctrl.asrc = 1'b1; ctrl.bsrc = BSRC_FOUR;
        ctrl.branch = 1'b1; ctrl.wen = 1'b1;
        illegal = (f3_s != 3'b000);
      end
      TYPE_BRANCH: begin
        ctrl.imm = IMM_B; ctrl.branch = 1'b1;
        case (f3_s)
          3'b000, 3'b001: ctrl.sel = ALU_SUB;
          3'b100, 3'b101: ctrl.sel = ALU_SLT;
          3'b110, 3'b111: ctrl.sel = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      TYPE_LOAD: begin
        ctrl.imm = IMM_I; ctrl.bsrc = BSRC_IMM; ctrl.load = 1'b1; ctrl.wen = 1'b1;
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
          3'b011, 3'b110:                         illegal = !RV64;
          default:                                illegal = 1'b1;
        endcase
      end
      TYPE_STORE: begin
        ctrl.imm = IMM_S; ctrl.bsrc = BSRC_IMM; ctrl.store = 1'b1;
        case (f3_s)
          3'b000, 3'b001, 3'b010: illegal = 1'b0;
          3'b011:                 illegal = !RV64;
          default:                illegal = 1'b1;
        endcase
      end
      TYPE_OP_IMM: begin
        ctrl.imm = IMM_I; ctrl.bsrc = BSRC_IMM; ctrl.wen = 1'b1;
        ctrl.sel = alu_base(f3_s, (f3_s == 3'b101) && inst[30]);
        // RV64 shift amounts are 6 bits wide, so only inst[31:26] is funct
        case (f3_s)
          3'b001:  illegal = RV64 ? (inst[31:26] != 6'b000000) : (f7_s != 7'b0000000);
          3'b101:  illegal = RV64 ? ((inst[31:26] != 6'b000000) && (inst[31:26] != 6'b010000))
                                  : ((f7_s != 7'b0000000) && (f7_s != 7'b0100000));
          default: illegal = 1'b0;
        endcase
      end
      TYPE_OP: begin
        ctrl.wen = 1'b1;
        case (f7_s)
          7'b0000000: ctrl.sel = alu_base(f3_s, 1'b0);
          7'b0100000: begin
            ctrl.sel = alu_base(f3_s, 1'b1);
            illegal  = (f3_s != 3'b000) && (f3_s != 3'b101);
          end
          7'b0000001: begin
            ctrl.mop = 1'b1; ctrl.sel = mdu_op(f3_s); illegal = !SUPPORT_M;
          end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_OP_IMM_32: begin
        ctrl.imm = IMM_I; ctrl.bsrc = BSRC_IMM; ctrl.wen = 1'b1; ctrl.word = 1'b1;
        case (f3_s)
          3'b000: ctrl.sel = ALU_ADD;
          3'b001: begin ctrl.sel = ALU_SLL; illegal = (f7_s != 7'b0000000); end
          3'b101: begin
            ctrl.sel = alu_base(f3_s, inst[30]);
            illegal  = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
          end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_OP_32: begin
        ctrl.wen = 1'b1; ctrl.word = 1'b1;
        case (f7_s)
          7'b0000000: begin
            ctrl.sel = alu_base(f3_s, 1'b0);
            illegal  = !(f3_s inside {3'b000, 3'b001, 3'b101});
          end
          7'b0100000: begin
            ctrl.sel = alu_base(f3_s, 1'b1);
            illegal  = !(f3_s inside {3'b000, 3'b101});
          end
          7'b0000001: begin
            ctrl.mop = 1'b1; ctrl.sel = mdu_op(f3_s);
            illegal  = !SUPPORT_M || (f3_s inside {3'b001, 3'b010, 3'b011});
          end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_SYSTEM: begin
        ebreak  = (inst == INST_EBREAK);
        illegal = (inst != INST_EBREAK);
      end
      default: illegal = 1'b1;
    endcase
    illegal   = illegal | (!RV64 && ((opcode_s == TYPE_OP_IMM_32) || (opcode_s == TYPE_OP_32)));
    ctrl.word = ctrl.word & RV64;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback for one
// instruction at a time, latches decoded controls and counts retired instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0,
  parameter int CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  output logic             imem_req,
  input  logic             imem_rvalid,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rvalid,
  output logic             mdu_start,
  input  logic             mdu_done,
  output logic             ir_we,
  output logic [2:0]       op_imm,
  output logic             alu_asrc,
  output logic [1:0]       alu_bsrc,
  output logic [4:0]       alu_sel,
  output logic             alu_word,
  output logic             branch,
  output logic             reg_we,
  output logic             pc_we,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             illegal
);

  state_e           state_r, state_s;
  ctrl_t            dec_s, ctrl_r;
  logic             dec_illegal_s, dec_ebreak_s;
  logic             illegal_pend_r, ebreak_pend_r, illegal_r, mdu_wait_r;
  logic [CNT_W-1:0] instret_r;

  ctrl_decode #(.XLEN(XLEN), .SUPPORT_M(SUPPORT_M)) u_decode (
    .inst    (inst),
    .ctrl    (dec_s),
    .illegal (dec_illegal_s),
    .ebreak  (dec_ebreak_s)
  );

  // next-state and per-phase strobes
  always_comb begin
    state_s   = state_r;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mdu_start = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    case (state_r)
      ST_IDLE: state_s = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_we   = 1'b1;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (illegal_pend_r || ebreak_pend_r) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl_r.mop) begin
          mdu_start = ~mdu_wait_r;
          if (mdu_done) begin
            state_s = ST_WB;
          end else begin
            state_s = ST_EXEC;
          end
        end else if (ctrl_r.load || ctrl_r.store) begin
          state_s = ST_MEM;
        end else begin
          state_s = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_r.store;
        if (dmem_rvalid) begin
          pc_we   = ctrl_r.store;
          state_s = ctrl_r.store ? ST_FETCH : ST_WB;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_we  = ctrl_r.wen;
        pc_we   = 1'b1;
        state_s = ST_FETCH;
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_IDLE;
    endcase
  end

  // state, decoded-control latch and halt cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ctrl_r         <= '0;
      illegal_pend_r <= 1'b0;
      ebreak_pend_r  <= 1'b0;
      illegal_r      <= 1'b0;
      mdu_wait_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      // decode result is captured with the instruction so it is stable from DECODE on
      if (state_r == ST_FETCH && imem_rvalid) begin
        ctrl_r         <= dec_s;
        illegal_pend_r <= dec_illegal_s;
        ebreak_pend_r  <= dec_ebreak_s;
      end
      if (state_r == ST_DECODE && illegal_pend_r) begin
        illegal_r <= 1'b1;
      end
      mdu_wait_r <= (state_r == ST_EXEC) && ctrl_r.mop && !mdu_done;
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (pc_we) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign op_imm   = ctrl_r.imm;
  assign alu_asrc = ctrl_r.asrc;
  assign alu_bsrc = ctrl_r.bsrc;
  assign alu_sel  = ctrl_r.sel;
  assign alu_word = ctrl_r.word;
  assign branch   = ctrl_r.branch;
  assign instret  = instret_r;
  assign halted   = (state_r == ST_HALT);
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: u_a is RV32 without M, u_b is RV64 with M and a 4-bit counter;
// both share stimulus so each scenario exercises both configurations.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_LW     = 32'h0000_2103;
  localparam logic [31:0] I_SW     = 32'h0010_2023;
  localparam logic [31:0] I_MUL    = 32'h0220_81B3;
  localparam logic [31:0] I_ADDW   = 32'h0010_80BB;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        imem_rvalid = 1'b0, dmem_rvalid = 1'b0, mdu_done = 1'b0;

  logic a_imem_req, a_dmem_req, a_dmem_we, a_mdu_start, a_ir_we, a_alu_asrc, a_alu_word;
  logic a_branch, a_reg_we, a_pc_we, a_halted, a_illegal;
  logic [2:0] a_op_imm; logic [1:0] a_alu_bsrc; logic [4:0] a_alu_sel; logic [63:0] a_instret;
  logic b_imem_req, b_dmem_req, b_dmem_we, b_mdu_start, b_ir_we, b_alu_asrc, b_alu_word;
  logic b_branch, b_reg_we, b_pc_we, b_halted, b_illegal;
  logic [2:0] b_op_imm; logic [1:0] b_alu_bsrc; logic [4:0] b_alu_sel; logic [3:0] b_instret;
  logic [21:0] a_all, b_all;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(64)) u_a (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_req(a_imem_req), .imem_rvalid(imem_rvalid),
    .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_rvalid(dmem_rvalid),
    .mdu_start(a_mdu_start), .mdu_done(mdu_done), .ir_we(a_ir_we), .op_imm(a_op_imm),
    .alu_asrc(a_alu_asrc), .alu_bsrc(a_alu_bsrc), .alu_sel(a_alu_sel), .alu_word(a_alu_word),
    .branch(a_branch), .reg_we(a_reg_we), .pc_we(a_pc_we), .instret(a_instret),
    .halted(a_halted), .illegal(a_illegal));

  multicycle_ctrl #(.XLEN(64), .SUPPORT_M(1'b1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_req(b_imem_req), .imem_rvalid(imem_rvalid),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_rvalid(dmem_rvalid),
    .mdu_start(b_mdu_start), .mdu_done(mdu_done), .ir_we(b_ir_we), .op_imm(b_op_imm),
    .alu_asrc(b_alu_asrc), .alu_bsrc(b_alu_bsrc), .alu_sel(b_alu_sel), .alu_word(b_alu_word),
    .branch(b_branch), .reg_we(b_reg_we), .pc_we(b_pc_we), .instret(b_instret),
    .halted(b_halted), .illegal(b_illegal));

  assign a_all = {a_imem_req, a_dmem_req, a_dmem_we, a_mdu_start, a_ir_we, a_op_imm, a_alu_asrc,
                  a_alu_bsrc, a_alu_sel, a_alu_word, a_branch, a_reg_we, a_pc_we, a_halted, a_illegal};
  assign b_all = {b_imem_req, b_dmem_req, b_dmem_we, b_mdu_start, b_ir_we, b_op_imm, b_alu_asrc,
                  b_alu_bsrc, b_alu_sel, b_alu_word, b_branch, b_reg_we, b_pc_we, b_halted, b_illegal};

  task automatic cyc();
    @(negedge clk);
  endtask

  // drive an instruction in a FETCH cycle; returns in the DECODE cycle
  task automatic fetch(input logic [31:0] instr);
    inst = instr; imem_rvalid = 1'b1;
    cyc();
    imem_rvalid = 1'b0; inst = 32'd0;
  endtask

  // returns in the IDLE cycle right after reset release
  task automatic do_reset();
    rst_n = 1'b0; inst = 32'd0; imem_rvalid = 1'b0; dmem_rvalid = 1'b0; mdu_done = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); #1;
    vectors++; if (a_all !== 22'd0) begin miscompares++; $display("FAIL reset_a_outputs: got %h need %h", a_all, 22'd0); end
    vectors++; if (b_all !== 22'd0) begin miscompares++; $display("FAIL reset_b_outputs: got %h need %h", b_all, 22'd0); end
    vectors++; if (a_instret !== 64'd0 || b_instret !== 4'd0) begin miscompares++; $display("FAIL reset_instret: got %0d/%0d need 0/0", a_instret, b_instret); end
    rst_n = 1'b1; #1;
    vectors++; if (a_all !== 22'd0) begin miscompares++; $display("FAIL idle_outputs: got %h need %h", a_all, 22'd0); end
  endtask

  task automatic test_addi();
    cyc(); inst = I_ADDI; imem_rvalid = 1'b1; #1;
    vectors++; if ({a_imem_req, a_ir_we, b_imem_req, b_ir_we} !== 4'b1111) begin miscompares++; $display("FAIL addi_fetch_c2: got %b need 1111", {a_imem_req, a_ir_we, b_imem_req, b_ir_we}); end
    cyc(); imem_rvalid = 1'b0; inst = 32'd0; #1;
    vectors++; if ({a_imem_req, a_ir_we, a_reg_we, a_pc_we, a_op_imm} !== {4'b0000, IMM_I}) begin miscompares++; $display("FAIL addi_decode_c3: got %b need %b", {a_imem_req, a_ir_we, a_reg_we, a_pc_we, a_op_imm}, {4'b0000, IMM_I}); end
    cyc(); #1;
    vectors++; if ({a_alu_bsrc, a_op_imm, a_alu_asrc, a_alu_sel, a_reg_we} !== {BSRC_IMM, IMM_I, 1'b0, ALU_ADD, 1'b0}) begin miscompares++; $display("FAIL addi_exec_c4: got %b need %b", {a_alu_bsrc, a_op_imm, a_alu_asrc, a_alu_sel, a_reg_we}, {BSRC_IMM, IMM_I, 1'b0, ALU_ADD, 1'b0}); end
    cyc(); #1;
    vectors++; if ({a_reg_we, a_pc_we, b_reg_we, b_pc_we} !== 4'b1111) begin miscompares++; $display("FAIL addi_wb_c5: got %b need 1111", {a_reg_we, a_pc_we, b_reg_we, b_pc_we}); end
    cyc(); #1;
    vectors++; if (a_instret !== 64'd1 || b_instret !== 4'd1 || a_imem_req !== 1'b1) begin miscompares++; $display("FAIL addi_retire: got %0d/%0d req %b need 1/1 req 1", a_instret, b_instret, a_imem_req); end
  endtask

  task automatic test_load();
    int req_cnt = 0;
    logic we_seen = 1'b0, early = 1'b0;
    fetch(I_LW);
    cyc(); #1;
    vectors++; if (a_dmem_req !== 1'b0) begin miscompares++; $display("FAIL lw_exec_req: got %b need 0", a_dmem_req); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_rvalid = (i == 3); #1;
      req_cnt += int'(a_dmem_req);
      we_seen |= a_dmem_we;
      early |= a_reg_we | a_pc_we;
      cyc();
    end
    dmem_rvalid = 1'b0; #1;
    vectors++; if ({a_reg_we, a_pc_we, a_dmem_req} !== 3'b110) begin miscompares++; $display("FAIL lw_wb: got %b need 110", {a_reg_we, a_pc_we, a_dmem_req}); end
    vectors++; if (req_cnt != 4 || we_seen !== 1'b0 || early !== 1'b0) begin miscompares++; $display("FAIL lw_mem_wait: got req=%0d we=%b wb=%b need 4/0/0", req_cnt, we_seen, early); end
    cyc(); #1;
    vectors++; if (a_instret !== 64'd2 || a_imem_req !== 1'b1) begin miscompares++; $display("FAIL lw_retire: got %0d req %b need 2 req 1", a_instret, a_imem_req); end
  endtask

  task automatic test_store();
    logic rw = 1'b0;
    fetch(I_SW); #1;
    rw |= a_reg_we;
    cyc(); #1;
    rw |= a_reg_we;
    cyc(); dmem_rvalid = 1'b1; #1;
    vectors++; if ({a_dmem_req, a_dmem_we, a_pc_we, a_reg_we, b_dmem_we} !== 5'b11101) begin miscompares++; $display("FAIL sw_mem: got %b need 11101", {a_dmem_req, a_dmem_we, a_pc_we, a_reg_we, b_dmem_we}); end
    cyc(); dmem_rvalid = 1'b0; #1;
    vectors++; if (a_imem_req !== 1'b1 || a_instret !== 64'd3 || rw !== 1'b0) begin miscompares++; $display("FAIL sw_retire: got req %b cnt %0d rw %b need 1/3/0", a_imem_req, a_instret, rw); end
  endtask

  task automatic test_ebreak();
    logic act = 1'b0;
    fetch(I_EBREAK); #1;
    vectors++; if (a_halted !== 1'b0) begin miscompares++; $display("FAIL ebreak_decode: got halted %b need 0", a_halted); end
    cyc(); #1;
    vectors++; if ({a_halted, a_illegal, b_halted, b_illegal} !== 4'b1010) begin miscompares++; $display("FAIL ebreak_halt: got %b need 1010", {a_halted, a_illegal, b_halted, b_illegal}); end
    vectors++; if (a_instret !== 64'd3 || b_instret !== 4'd3) begin miscompares++; $display("FAIL ebreak_instret: got %0d/%0d need 3/3", a_instret, b_instret); end
    inst = I_ADDI; imem_rvalid = 1'b1; dmem_rvalid = 1'b1; mdu_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      act |= a_imem_req | a_ir_we | a_reg_we | a_pc_we | a_dmem_req | a_mdu_start;
      act |= b_imem_req | b_ir_we | b_reg_we | b_pc_we | b_dmem_req | b_mdu_start;
    end
    vectors++; if (act !== 1'b0 || a_halted !== 1'b1 || a_instret !== 64'd3) begin miscompares++; $display("FAIL halt_absorbing: got act %b halted %b cnt %0d need 0/1/3", act, a_halted, a_instret); end
  endtask

  task automatic test_mul();
    int starts = 0;
    logic early = 1'b0;
    do_reset(); cyc();
    fetch(I_MUL); cyc();
    for (int i = 0; i < 5; i++) begin
      mdu_done = (i == 4); #1;
      starts += int'(b_mdu_start);
      early |= b_reg_we | b_pc_we;
      if (i == 0) begin
        vectors++; if (b_alu_sel !== ALU_MUL) begin miscompares++; $display("FAIL mul_sel: got %0d need %0d", b_alu_sel, ALU_MUL); end
      end
      cyc();
    end
    mdu_done = 1'b0; #1;
    vectors++; if ({b_reg_we, b_pc_we} !== 2'b11 || starts != 1 || early !== 1'b0) begin miscompares++; $display("FAIL mul_wb: got wb %b starts %0d early %b need 11/1/0", {b_reg_we, b_pc_we}, starts, early); end
    vectors++; if ({a_halted, a_illegal, a_mdu_start} !== 3'b110 || a_instret !== 64'd0) begin miscompares++; $display("FAIL mul_no_m_halt: got %b cnt %0d need 110 cnt 0", {a_halted, a_illegal, a_mdu_start}, a_instret); end
    cyc();
    fetch(I_MUL); cyc(); mdu_done = 1'b1; #1;
    vectors++; if (b_mdu_start !== 1'b1) begin miscompares++; $display("FAIL mul_fast_start: got %b need 1", b_mdu_start); end
    cyc(); mdu_done = 1'b0; #1;
    vectors++; if ({b_reg_we, b_pc_we, b_mdu_start} !== 3'b110) begin miscompares++; $display("FAIL mul_fast_wb: got %b need 110", {b_reg_we, b_pc_we, b_mdu_start}); end
    cyc(); #1;
    vectors++; if (b_instret !== 4'd2) begin miscompares++; $display("FAIL mul_instret: got %0d need 2", b_instret); end
  endtask

  task automatic test_addw();
    do_reset(); cyc();
    fetch(I_ADDW); cyc(); #1;
    vectors++; if ({b_alu_word, b_alu_sel, b_alu_bsrc} !== {1'b1, ALU_ADD, BSRC_RS2}) begin miscompares++; $display("FAIL addw_rv64: got %b need %b", {b_alu_word, b_alu_sel, b_alu_bsrc}, {1'b1, ALU_ADD, BSRC_RS2}); end
    vectors++; if ({a_halted, a_illegal, a_alu_word} !== 3'b110) begin miscompares++; $display("FAIL addw_rv32_illegal: got %b need 110", {a_halted, a_illegal, a_alu_word}); end
    cyc(); #1;
    vectors++; if ({b_reg_we, b_pc_we} !== 2'b11) begin miscompares++; $display("FAIL addw_wb: got %b need 11", {b_reg_we, b_pc_we}); end
  endtask

  task automatic test_decode_table();
    logic [31:0] t_inst [8] = '{32'h4030D093, 32'h402080B3, 32'hC0000093, 32'h00000063,
                                32'h00006063, 32'h00005063, 32'h000000EF, 32'h00000097};
    alu_op_e t_sel [8] = '{ALU_SRA, ALU_SUB, ALU_ADD, ALU_SUB, ALU_SLTU, ALU_SLT, ALU_ADD, ALU_ADD};
    logic t_asrc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] t_bsrc [8] = '{BSRC_IMM, BSRC_RS2, BSRC_IMM, BSRC_RS2, BSRC_RS2, BSRC_RS2, BSRC_FOUR, BSRC_IMM};
    imm_e t_imm [8] = '{IMM_I, IMM_R, IMM_I, IMM_B, IMM_B, IMM_B, IMM_J, IMM_U};
    logic t_br [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic t_wen [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] exp_v;
    do_reset(); cyc();
    for (int i = 0; i < 8; i++) begin
      exp_v = {t_sel[i], t_asrc[i], t_bsrc[i], t_imm[i], t_br[i]};
      fetch(t_inst[i]); cyc(); #1;
      vectors++; if ({a_alu_sel, a_alu_asrc, a_alu_bsrc, a_op_imm, a_branch} !== exp_v || {b_alu_sel, b_alu_asrc, b_alu_bsrc, b_op_imm, b_branch} !== exp_v) begin miscompares++; $display("FAIL decode_%0d_%h: got %b/%b need %b", i, t_inst[i], {a_alu_sel, a_alu_asrc, a_alu_bsrc, a_op_imm, a_branch}, {b_alu_sel, b_alu_asrc, b_alu_bsrc, b_op_imm, b_branch}, exp_v); end
      cyc(); #1;
      vectors++; if ({a_reg_we, a_pc_we, b_reg_we, b_pc_we} !== {t_wen[i], 1'b1, t_wen[i], 1'b1}) begin miscompares++; $display("FAIL decode_wb_%0d: got %b need %b", i, {a_reg_we, a_pc_we, b_reg_we, b_pc_we}, {t_wen[i], 1'b1, t_wen[i], 1'b1}); end
      cyc();
    end
    #1;
    vectors++; if (a_instret !== 64'd8 || b_instret !== 4'd8) begin miscompares++; $display("FAIL decode_instret: got %0d/%0d need 8/8", a_instret, b_instret); end
  endtask

  task automatic test_wrap();
    do_reset(); cyc();
    for (int k = 0; k < 16; k++) begin
      fetch(I_ADDI); cyc(); cyc(); cyc(); #1;
      if (k == 14) begin
        vectors++; if (b_instret !== 4'hF) begin miscompares++; $display("FAIL wrap_max: got %0d need 15", b_instret); end
      end
    end
    vectors++; if (b_instret !== 4'd0 || a_instret !== 64'd16) begin miscompares++; $display("FAIL wrap_zero: got %0d/%0d need 0/16", b_instret, a_instret); end
  endtask

  task automatic test_reset_mid_mem();
    fetch(I_LW); cyc(); cyc(); #1;
    vectors++; if ({a_dmem_req, b_dmem_req} !== 2'b11) begin miscompares++; $display("FAIL midmem_req: got %b need 11", {a_dmem_req, b_dmem_req}); end
    rst_n = 1'b0; #1;
    vectors++; if (a_all !== 22'd0 || b_all !== 22'd0) begin miscompares++; $display("FAIL midmem_reset_outputs: got %h/%h need 0/0", a_all, b_all); end
    vectors++; if (a_instret !== 64'd0 || b_instret !== 4'd0) begin miscompares++; $display("FAIL midmem_reset_instret: got %0d/%0d need 0/0", a_instret, b_instret); end
    cyc(); rst_n = 1'b1; #1;
    vectors++; if ({a_imem_req, b_imem_req} !== 2'b00) begin miscompares++; $display("FAIL restart_idle: got %b need 00", {a_imem_req, b_imem_req}); end
    cyc(); #1;
    vectors++; if ({a_imem_req, b_imem_req, a_dmem_req} !== 3'b110) begin miscompares++; $display("FAIL restart_fetch: got %b need 110", {a_imem_req, b_imem_req, a_dmem_req}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_ebreak();
    test_mul();
    test_addw();
    test_decode_table();
    test_wrap();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish need finish");
    $fatal(1);
  end

endmodule
